// File: rtl/fifo_multi_read_pkg.sv
// Width helpers shared by the FIFO family: pointer and occupancy widths derived from DEPTH.
package fifo_multi_read_pkg;

  // Pointer width for indices 0..depth-1; never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy width for counts 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Enabled index counter over 0..DEPTH-1 with an explicit wrap, so DEPTH need not be a power of two.
module fifo_wrap_ptr
  import fifo_multi_read_pkg::*;
#(
  parameter int unsigned DEPTH = 2560
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  output logic [addr_w(DEPTH)-1:0]   ptr
);

  localparam int unsigned ADDR_W = addr_w(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      if (ptr == LAST) ptr <= '0;
      else             ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_multi_read.sv
// Single-writer broadcast FIFO: each of NUM_RD readers consumes every word once, at its own pace.
// A slot is reusable only once the slowest reader has passed it.
module fifo_multi_read
  import fifo_multi_read_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 128,
  parameter int unsigned DEPTH             = 2560,
  parameter int unsigned NUM_RD            = 3,
  parameter int unsigned ALMOST_FULL_THRES = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic                              wr_en,
  output logic                              full,
  output logic                              almost_full,
  input  logic [NUM_RD-1:0]                 rd_en,
  output logic [NUM_RD*DATA_WIDTH-1:0]      rd_data,
  output logic [NUM_RD-1:0]                 rd_valid,
  output logic [NUM_RD-1:0]                 empty,
  output logic [NUM_RD*cnt_w(DEPTH)-1:0]    rd_count,
  output logic                              overflow,
  output logic [NUM_RD-1:0]                 underflow
);

  localparam int unsigned ADDR_W = addr_w(DEPTH);
  localparam int unsigned CNT_W  = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr [NUM_RD];
  logic [CNT_W-1:0]      cnt    [NUM_RD];
  logic [CNT_W-1:0]      max_cnt;
  logic [CNT_W-1:0]      free_slots;
  logic                  wr_acc;
  logic [NUM_RD-1:0]     rd_acc;

  // Acceptance uses only registered state, so no output depends combinationally on an input.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .en  (wr_acc),
    .ptr (wr_ptr)
  );

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_ptr
    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .en  (rd_acc[g]),
      .ptr (rd_ptr[g])
    );
  end

  // Contents survive reset; pointers and counts alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  // A reader can never target the slot being written: that slot is unread only while the reader is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_RD; i++) begin
        rd_valid[i] <= rd_acc[i];
        if (rd_acc[i]) rd_data[i*DATA_WIDTH +: DATA_WIDTH] <= mem[rd_ptr[i]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_RD; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_RD; i++) begin
        case ({wr_acc, rd_acc[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= '0;
    end else begin
      overflow  <= overflow | (wr_en & full);
      underflow <= underflow | (rd_en & empty);
    end
  end

  always_comb begin
    rd_count = '0;
    empty    = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_count[i*CNT_W +: CNT_W] = cnt[i];
      empty[i] = (cnt[i] == '0);
    end
  end

  // Slowest reader's backlog determines how much storage is still occupied.
  always_comb begin
    max_cnt = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (cnt[i] > max_cnt) max_cnt = cnt[i];
    end
  end

  always_comb begin
    free_slots  = DEPTH_C - max_cnt;
    full        = (max_cnt == DEPTH_C);
    almost_full = (32'(free_slots) <= ALMOST_FULL_THRES);
  end

endmodule

// File: tb/tb_fifo_multi_read.sv
// Scoreboard bench for fifo_multi_read: DEPTH=6 instance for general behaviour, DEPTH=5 instance for wrap-around.
module tb_fifo_multi_read;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 3;
  localparam int unsigned CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0]    a_wr_data = '0;
  logic             a_wr_en   = 1'b0;
  logic [NR-1:0]    a_rd_en   = '0;
  logic             a_full, a_almost_full, a_overflow;
  logic [NR*DW-1:0] a_rd_data;
  logic [NR-1:0]    a_rd_valid, a_empty, a_underflow;
  logic [NR*CW-1:0] a_rd_count;

  logic [DW-1:0]    b_wr_data = '0;
  logic             b_wr_en   = 1'b0;
  logic [NR-1:0]    b_rd_en   = '0;
  logic             b_full, b_almost_full, b_overflow;
  logic [NR*DW-1:0] b_rd_data;
  logic [NR-1:0]    b_rd_valid, b_empty, b_underflow;
  logic [NR*CW-1:0] b_rd_count;

  fifo_multi_read #(.DATA_WIDTH(DW), .DEPTH(6), .NUM_RD(NR), .ALMOST_FULL_THRES(2)) dut_a (
    .clk(clk), .rst(rst), .wr_data(a_wr_data), .wr_en(a_wr_en), .full(a_full),
    .almost_full(a_almost_full), .rd_en(a_rd_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .empty(a_empty), .rd_count(a_rd_count), .overflow(a_overflow), .underflow(a_underflow)
  );

  fifo_multi_read #(.DATA_WIDTH(DW), .DEPTH(5), .NUM_RD(NR), .ALMOST_FULL_THRES(2)) dut_b (
    .clk(clk), .rst(rst), .wr_data(b_wr_data), .wr_en(b_wr_en), .full(b_full),
    .almost_full(b_almost_full), .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .empty(b_empty), .rd_count(b_rd_count), .overflow(b_overflow), .underflow(b_underflow)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [DW-1:0] model_q [NR][$];
  logic [DW-1:0] exp_q   [NR][$];
  logic [DW-1:0] exp_b   [$];
  logic          m_ovf;
  logic [NR-1:0] m_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned model_max();
    int unsigned mx = 0;
    for (int r = 0; r < NR; r++)
      if (model_q[r].size() > mx) mx = model_q[r].size();
    return mx;
  endfunction

  task automatic check_flags_a(input string tag);
    int unsigned mx = model_max();
    for (int r = 0; r < NR; r++) begin
      check($sformatf("%s rd_count[%0d]", tag, r), 32'(a_rd_count[r*CW +: CW]), model_q[r].size());
      check($sformatf("%s empty[%0d]", tag, r), 32'(a_empty[r]), 32'(model_q[r].size() == 0));
    end
    check({tag, " full"}, 32'(a_full), 32'(mx == 6));
    check({tag, " almost_full"}, 32'(a_almost_full), 32'((6 - mx) <= 2));
    check({tag, " overflow"}, 32'(a_overflow), 32'(m_ovf));
    check({tag, " underflow"}, 32'(a_underflow), 32'(m_unf));
  endtask

  task automatic step_a(input string tag, input logic we, input logic [DW-1:0] wd, input logic [NR-1:0] re);
    logic          full_m;
    logic [NR-1:0] vexp;
    @(negedge clk);
    a_wr_en = we; a_wr_data = wd; a_rd_en = re;
    full_m = (model_max() == 6);
    vexp = '0;
    if (we && full_m) m_ovf = 1'b1;
    for (int r = 0; r < NR; r++) begin
      if (re[r] && model_q[r].size() == 0) m_unf[r] = 1'b1;
      if (re[r] && model_q[r].size() != 0) begin
        exp_q[r].push_back(model_q[r].pop_front());
        vexp[r] = 1'b1;
      end
    end
    if (we && !full_m)
      for (int r = 0; r < NR; r++) model_q[r].push_back(wd);
    @(posedge clk); #1;
    for (int r = 0; r < NR; r++) begin
      check($sformatf("%s rd_valid[%0d]", tag, r), 32'(a_rd_valid[r]), 32'(vexp[r]));
      if (a_rd_valid[r]) begin
        if (exp_q[r].size() == 0)
          check($sformatf("%s unexpected rd_data[%0d]", tag, r), 32'(a_rd_data[r*DW +: DW]), 32'hFFFF_FFFF);
        else
          check($sformatf("%s rd_data[%0d]", tag, r), 32'(a_rd_data[r*DW +: DW]), 32'(exp_q[r].pop_front()));
      end
    end
    check_flags_a(tag);
  endtask

  task automatic do_reset(input string tag, input logic we);
    @(negedge clk);
    rst = 1'b1; a_wr_en = we; a_wr_data = 8'hEE; a_rd_en = '0;
    @(posedge clk); #1;
    for (int r = 0; r < NR; r++) begin
      model_q[r].delete();
      exp_q[r].delete();
    end
    m_ovf = 1'b0;
    m_unf = '0;
    check({tag, " rd_valid"}, 32'(a_rd_valid), 32'h0);
    check({tag, " rd_data"}, 32'(a_rd_data), 32'h0);
    check_flags_a(tag);
    @(negedge clk);
    rst = 1'b0; a_wr_en = 1'b0; a_rd_en = '0;
  endtask

  initial begin
    m_ovf = 1'b0;
    m_unf = '0;
    repeat (2) @(posedge clk);

    // 1: reset then idle
    do_reset("t1 reset", 1'b0);
    step_a("t1 idle", 1'b0, 8'h00, 3'b000);
    step_a("t1 idle", 1'b0, 8'h00, 3'b000);

    // 2: two writes, reader1 reads both back-to-back
    step_a("t2 wr", 1'b1, 8'h11, 3'b000);
    step_a("t2 wr", 1'b1, 8'h22, 3'b000);
    step_a("t2 rd1", 1'b0, 8'h00, 3'b010);
    step_a("t2 rd1", 1'b0, 8'h00, 3'b010);
    step_a("t2 idle", 1'b0, 8'h00, 3'b000);

    // 3: fill to full, overflow, reader0 drains alone
    do_reset("t3 reset", 1'b0);
    for (int i = 0; i < 6; i++) step_a($sformatf("t3 wr%0d", i), 1'b1, 8'(8'hA0 + i), 3'b000);
    step_a("t3 wr_full", 1'b1, 8'hFF, 3'b000);
    for (int i = 0; i < 6; i++) step_a($sformatf("t3 drain%0d", i), 1'b0, 8'h00, 3'b001);
    step_a("t3 wr_full_rd", 1'b1, 8'hFE, 3'b110);

    // 5: concurrent write and read on all readers at count 3, then underflow
    do_reset("t5 reset", 1'b0);
    for (int i = 0; i < 3; i++) step_a("t5 wr", 1'b1, 8'(8'h31 + i), 3'b000);
    for (int i = 0; i < 3; i++) step_a("t5 wr_rd", 1'b1, 8'(8'h40 + i), 3'b111);
    for (int i = 0; i < 3; i++) step_a("t5 rd", 1'b0, 8'h00, 3'b111);
    step_a("t5 underflow", 1'b0, 8'h00, 3'b100);
    step_a("t5 idle", 1'b0, 8'h00, 3'b000);

    // 6: reset mid-stream with a write request pending
    do_reset("t6 reset", 1'b0);
    for (int i = 0; i < 4; i++) step_a("t6 wr", 1'b1, 8'(8'h60 + i), 3'b000);
    do_reset("t6 midreset", 1'b1);
    step_a("t6 wr_after", 1'b1, 8'h5A, 3'b000);
    step_a("t6 rd_after", 1'b0, 8'h00, 3'b111);

    // 4: DEPTH=5 wrap-around, all readers following one cycle behind the writer
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      b_wr_en   = (k < 13);
      b_wr_data = 8'(k);
      b_rd_en   = (k > 0) ? 3'b111 : 3'b000;
      if (k > 0) exp_b.push_back(8'(k - 1));
      @(posedge clk); #1;
      if (k == 0) begin
        check("t4 first rd_valid", 32'(b_rd_valid), 32'h0);
      end else begin
        logic [DW-1:0] e;
        e = exp_b.pop_front();
        check($sformatf("t4 rd_valid k%0d", k), 32'(b_rd_valid), 32'h7);
        for (int r = 0; r < NR; r++)
          check($sformatf("t4 rd_data[%0d] k%0d", r, k), 32'(b_rd_data[r*DW +: DW]), 32'(e));
      end
      for (int r = 0; r < NR; r++)
        check($sformatf("t4 count<=1 [%0d] k%0d", r, k), 32'(b_rd_count[r*CW +: CW] <= 1), 32'h1);
      check($sformatf("t4 full k%0d", k), 32'(b_full), 32'h0);
    end
    @(negedge clk);
    b_wr_en = 1'b0; b_rd_en = '0;
    check("t4 empty", 32'(b_empty), 32'h7);
    check("t4 flags", 32'({b_overflow, b_underflow}), 32'h0);

    for (int r = 0; r < NR; r++)
      check($sformatf("leftover exp_q[%0d]", r), exp_q[r].size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
